reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file with write-through bypass, optional hardwired zero

---
 rtl/reg_file_sb_pkg.sv | 12 +
 rtl/reg_file_sb_scoreboard.sv | 45 ++++
 rtl/reg_file_sb.sv | 58 +++++
 tb/tb_reg_file_sb.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared widths, zero-register address and scoreboard counter ops
package reg_file_sb_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;
    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_CLR
    } cnt_op_e;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_file_sb_scoreboard: pending-write busy bits with flush > claim > clear priority and popcount counter
module reg_file_sb_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   claim_en,
    input  logic [ADDR_W-1:0]      claim_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   flush,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        pend_cnt
);
    localparam int NUM_REGS = 2**ADDR_W;
    logic                claim_ok;
    logic                inc;
    logic                dec;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    cnt_op_e             op;
    always_comb begin
        claim_ok = claim_en && !(ZERO_REG != 0 && claim_addr == ADDR_W'(ZERO_ADDR));
        set_mask = claim_ok ? NUM_REGS'(1) << claim_addr : '0;
        clr_mask = wr_en ? NUM_REGS'(1) << wr_addr : '0;
        inc      = claim_ok && !busy[claim_addr];
        // a same-address claim keeps the bit set, so that write does not count down
        dec      = wr_en && busy[wr_addr] && !(claim_ok && claim_addr == wr_addr);
        op       = flush ? CNT_CLR : (inc && !dec) ? CNT_INC : (dec && !inc) ? CNT_DEC : CNT_HOLD;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= flush ? '0 : (busy & ~clr_mask) | set_mask;
            pend_cnt <= op == CNT_CLR ? '0 :
                        op == CNT_INC ? pend_cnt + 1'b1 :
                        op == CNT_DEC ? pend_cnt - 1'b1 : pend_cnt;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with write-through bypass, optional zero register and scoreboard
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt
);
    localparam int NUM_REGS = 2**ADDR_W;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr_en && !(ZERO_REG != 0 && wr_addr == ADDR_W'(ZERO_ADDR))) begin
            regs[wr_addr] <= wr_data;
        end
    end
    reg_file_sb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy       (busy),
        .pend_cnt   (pend_cnt)
    );
    // a same-cycle writeback both forwards its data and releases the stall
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              z;
        logic              hit;
        assign a   = rd_addr[i*ADDR_W +: ADDR_W];
        assign z   = ZERO_REG != 0 && a == ADDR_W'(ZERO_ADDR);
        assign hit = wr_en && wr_addr == a && !z;
        assign rd_data[i*DATA_W +: DATA_W] = z ? '0 : hit ? wr_data : regs[a];
        assign rd_busy[i] = busy[a] && !hit && !z;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table on a 2-port zero-reg build, reference-model stream on a 4-port build
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  a_ra = '0;
    logic [63:0] a_rd;
    logic [1:0]  a_busy;
    logic        a_we = 1'b0, a_ce = 1'b0, a_fl = 1'b0;
    logic [4:0]  a_wa = '0, a_ca = '0;
    logic [31:0] a_wd = '0;
    logic [5:0]  a_cnt;
    logic [19:0]  b_ra = '0;
    logic [127:0] b_rd;
    logic [3:0]   b_busy;
    logic         b_we = 1'b0, b_ce = 1'b0, b_fl = 1'b0;
    logic [4:0]   b_wa = '0, b_ca = '0;
    logic [31:0]  b_wd = '0;
    logic [5:0]   b_cnt;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    always #5 clk = ~clk;
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(a_ra), .rd_data(a_rd), .rd_busy(a_busy),
        .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .claim_en(a_ce), .claim_addr(a_ca),
        .flush(a_fl), .pend_cnt(a_cnt)
    );
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(b_ra), .rd_data(b_rd), .rd_busy(b_busy),
        .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .claim_en(b_ce), .claim_addr(b_ca),
        .flush(b_fl), .pend_cnt(b_cnt)
    );
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ce;
        logic [4:0]  ca;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] d0, d1;
        logic        b0, b1;
        logic [5:0]  cnt;
    } vec_t;
    vec_t vecs [18];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic b_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic ce, input logic [4:0] ca, input logic fl, input logic [4:0] base);
        logic [4:0] ra;
        logic       hit;
        @(negedge clk);
        b_we = we; b_wa = wa; b_wd = wd; b_ce = ce; b_ca = ca; b_fl = fl;
        b_ra = {base + 5'd3, base + 5'd2, base + 5'd1, base};
        #2;
        for (int i = 0; i < 4; i++) begin
            ra  = base + 5'(i);
            hit = we && wa == ra;
            chk($sformatf("b data%0d", i), b_rd[i*32 +: 32], hit ? wd : m_regs[ra]);
            chk($sformatf("b busy%0d", i), 32'(b_busy[i]), 32'(m_busy[ra] && !hit));
        end
        chk("b pend_cnt", 32'(b_cnt), 32'($countones(m_busy)));
        @(posedge clk);
        #1;
        if (we) m_regs[wa] = wd;
        if (fl) m_busy = '0;
        else begin
            if (we) m_busy[wa] = 1'b0;
            if (ce) m_busy[ca] = 1'b1;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        //           we    wa     wd            ce    ca     fl    ra0    ra1    d0            d1            b0    b1    cnt
        vecs[0]  = '{1'b1, 5'd7,  32'h18,       1'b0, 5'd0,  1'b0, 5'd7,  5'd0,  32'h18,       32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 5'd9,  32'hDEAD,     1'b0, 5'd0,  1'b0, 5'd7,  5'd9,  32'h18,       32'hDEAD,     1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd7,  32'hDEAD,     32'h18,       1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd4,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd3,  5'd4,  32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
        vecs[7]  = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  1'b0, 5'd3,  5'd4,  32'h33,       32'h0,        1'b0, 1'b1, 6'd2};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd4,  32'h33,       32'h0,        1'b0, 1'b1, 6'd1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  5'd4,  32'h0,        32'h0,        1'b0, 1'b1, 6'd1};
        vecs[10] = '{1'b1, 5'd5,  32'h55,       1'b1, 5'd5,  1'b0, 5'd5,  5'd4,  32'h55,       32'h0,        1'b0, 1'b1, 6'd2};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd4,  32'h55,       32'h0,        1'b1, 1'b1, 6'd2};
        vecs[12] = '{1'b1, 5'd8,  32'h88,       1'b1, 5'd6,  1'b1, 5'd6,  5'd8,  32'h0,        32'h88,       1'b0, 1'b0, 6'd2};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd6,  5'd8,  32'h0,        32'h88,       1'b0, 1'b0, 6'd0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 1'b0, 5'd10, 5'd5,  32'h0,        32'h55,       1'b0, 1'b0, 6'd0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 1'b0, 5'd10, 5'd5,  32'h0,        32'h55,       1'b1, 1'b0, 6'd1};
        vecs[16] = '{1'b1, 5'd11, 32'h11,       1'b0, 5'd0,  1'b0, 5'd10, 5'd11, 32'h0,        32'h11,       1'b1, 1'b0, 6'd1};
        vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd10, 5'd11, 32'h0,        32'h11,       1'b1, 1'b0, 6'd1};
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
        a_ra = {5'd9, 5'd7};
        b_ra = {5'd4, 5'd3, 5'd2, 5'd1};
        #3 reset = 1'b1;
        #1;
        chk("reset a data", a_rd[31:0] | a_rd[63:32], 32'h0);
        chk("reset a busy", 32'(a_busy), 32'h0);
        chk("reset a cnt", 32'(a_cnt), 32'h0);
        chk("reset b data", b_rd[31:0] | b_rd[63:32] | b_rd[95:64] | b_rd[127:96], 32'h0);
        chk("reset b busy", 32'(b_busy), 32'h0);
        chk("reset b cnt", 32'(b_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            a_we = vecs[i].we; a_wa = vecs[i].wa; a_wd = vecs[i].wd;
            a_ce = vecs[i].ce; a_ca = vecs[i].ca; a_fl = vecs[i].fl;
            a_ra = {vecs[i].ra1, vecs[i].ra0};
            #2;
            chk($sformatf("v%0d d0", i), a_rd[31:0], vecs[i].d0);
            chk($sformatf("v%0d d1", i), a_rd[63:32], vecs[i].d1);
            chk($sformatf("v%0d b0", i), 32'(a_busy[0]), 32'(vecs[i].b0));
            chk($sformatf("v%0d b1", i), 32'(a_busy[1]), 32'(vecs[i].b1));
            chk($sformatf("v%0d cnt", i), 32'(a_cnt), 32'(vecs[i].cnt));
        end
        // reset in the middle of a write and claim: takes effect at once and discards both
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd13; a_wd = 32'h77; a_ce = 1'b1; a_ca = 5'd14; a_fl = 1'b0;
        a_ra = {5'd10, 5'd7};
        #2 reset = 1'b1;
        #1;
        chk("midreset d0", a_rd[31:0], 32'h0);
        chk("midreset b1", 32'(a_busy[1]), 32'h0);
        chk("midreset cnt", 32'(a_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        a_we = 1'b0; a_ce = 1'b0;
        a_ra = {5'd14, 5'd13};
        #2;
        chk("postreset d0", a_rd[31:0], 32'h0);
        chk("postreset b1", 32'(a_busy[1]), 32'h0);
        chk("postreset cnt", 32'(a_cnt), 32'h0);
        // ordinary register 0 when ZERO_REG=0
        b_cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 1'b0, 5'd0);
        b_we = 1'b0; b_ce = 1'b0;
        #2;
        chk("r0 plain data", b_rd[31:0], 32'h55);
        chk("r0 plain busy", 32'(b_busy[0]), 32'h1);
        chk("r0 plain cnt", 32'(b_cnt), 32'h1);
        for (int n = 0; n < 300; n++)
            b_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 15) == 0, 5'($urandom_range(0, 7)));
        b_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
